punc_control: RTL and testbench
===============================

Name: punc_control

Overview:
- Multi-cycle control FSM for the PUnC LC3 processor; sits directly upstream of the PUnC datapath.
- Consumes the datapath instruction register (ir) and drives every datapath control input: memory, register file, PC, ALU, condition code and sign-extend selects.
- One instruction in flight; no pipelining.

Parameters:
(none)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
ir  input  16  current instruction from datapath
mem_wr_en  output  1  memory write strobe
mem_r_addr_sel  output  3  read addr: 0=PC, 1=PC+sext, 2=indirect latch, 3=mem read data, 4=ALU out
state2_STI  output  1  write addr from indirect latch (else PC+sext)
STR  output  1  write data from RF port1; PC+sext replaced by ALU out
RF_wr_addr  output  3  RF write address
RF_wr_en  output  1  RF write enable
RF_r_addr_0  output  3  RF read port0 address
RF_r_addr_1  output  3  RF read port1 address
RF_w_data_sel  output  2  RF write data: 0=ALU, 1=PC, 2=mem data, 3=PC+sext
ir_ld  output  1  load ir from memory read data
JMP_RET_JSRR  output  1  PC load source ALU out (else PC+sext)
pc_ld  output  1  unconditional PC load
pc_clr  output  1  clear PC
pc_up  output  1  PC increment
add_const  output  1  ALU B = sext constant (else RF port1)
alu_sel  output  2  0=PASS, 1=ADD, 2=AND, 3=NOT
cc_en  output  1  latch N/Z/P from ALU out
n, z, p  output  1 each  branch mask
const_n  output  11  always ir[10:0]
SEXT_Select  output  4  one-hot: 1000=imm5, 0100=off6, 0010=off9, 0001=off11
halted  output  1  high in HALT

Behaviour:
- States: INIT, FETCH, DECODE, EXEC1, EXEC2, CC_UPD, HALT.
- Outputs are combinational from state and ir. Every output not listed for a state is 0. const_n = ir[10:0] in all states.
- rst on an edge: next state INIT, from any state, including mid-instruction. No partial writes continue after reset.
- INIT: pc_clr=1 -> FETCH.
- FETCH: mem_r_addr_sel=0, ir_ld=1, pc_up=1 -> DECODE.
- DECODE: no strobes. Opcode ir[15:12]; TRAP(1111) -> HALT; otherwise -> EXEC1.
- EXEC1 by opcode. DR=ir[11:9], SR1/Base=ir[8:6].
  - ADD(0001)/AND(0101): r_addr_0=SR1, r_addr_1=ir[2:0], add_const=ir[5], SEXT=1000, alu_sel=1/2, w_data_sel=0, wr_addr=DR, wr_en, cc_en -> FETCH.
  - NOT(1001): r_addr_0=SR1, alu_sel=3, write DR, cc_en -> FETCH.
  - LD(0010): mem_r_addr_sel=1, SEXT=0010, w_data_sel=2, write DR -> CC_UPD.
  - LDR(0110): r_addr_0=Base, add_const, SEXT=0100, alu_sel=1, mem_r_addr_sel=4, w_data_sel=2, write DR -> CC_UPD.
  - LDI(1010): mem_r_addr_sel=1, SEXT=0010 (datapath latches pointer) -> EXEC2.
  - LEA(1110): SEXT=0010, w_data_sel=3, write DR -> CC_UPD.
  - ST(0011): r_addr_0=DR, alu_sel=0, SEXT=0010, mem_wr_en -> FETCH.
  - STR(0111): STR=1, r_addr_0=Base, r_addr_1=DR, add_const, SEXT=0100, alu_sel=1, mem_wr_en -> FETCH.
  - STI(1011): mem_r_addr_sel=1, SEXT=0010 -> EXEC2.
  - BR(0000): n,z,p=ir[11:9], SEXT=0010; datapath branches conditionally -> FETCH.
  - JMP/RET(1100): r_addr_0=Base, alu_sel=0, JMP_RET_JSRR, pc_ld -> FETCH.
  - JSR(0100, ir[11]=1): SEXT=0001, pc_ld, w_data_sel=1, wr_addr=7, wr_en -> FETCH. R7 captures incremented PC on the same edge the PC loads.
  - JSRR(ir[11]=0): as JMP plus R7 write (w_data_sel=1). Base=R7 legal; old R7 read.
  - RTI(1000)/reserved(1101): NOP -> FETCH.
- EXEC2:
  - LDI: mem_r_addr_sel=2, w_data_sel=2, write DR -> CC_UPD.
  - STI: state2_STI=1, r_addr_0=DR, alu_sel=0, mem_wr_en -> FETCH.
- CC_UPD: r_addr_0=DR, alu_sel=0, cc_en -> FETCH.
- HALT: halted=1, no strobes; held until rst.
- Cycles per instruction: ALU/store/branch/jump 3; LD/LDR/LEA 4; STI 4; LDI 5.

Optional Feature:
PUNC_INSTR_COUNT_EN
- Defined: adds output instr_count[15:0].
  - Cleared on rst.
  - Increments by 1 on each edge where the state leaves for FETCH from EXEC1/EXEC2/CC_UPD.
  - Wraps FFFF->0000.
  - Not incremented by INIT->FETCH or TRAP.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles, release -> INIT with pc_clr=1 for exactly 1 cycle; then FETCH with mem_r_addr_sel=0, ir_ld=1, pc_up=1; then DECODE with all strobes 0.
- ir=16'h1261 (ADD R1,R1,#1): EXEC1 shows r_addr_0=1, add_const=1, SEXT=1000, const_n=11'h261, alu_sel=1, wr_addr=1, wr_en=1, cc_en=1; FETCH again 3 cycles after the previous FETCH.
- ir=16'hA402 (LDI R2): EXEC1 mem_r_addr_sel=1, SEXT=0010; EXEC2 mem_r_addr_sel=2, w_data_sel=2, wr_addr=2, wr_en=1; CC_UPD r_addr_0=2, alu_sel=0, cc_en=1; 5-cycle instruction. Assert rst during EXEC2 -> INIT next cycle, no wr_en.
- ir=16'h05FE (BRz -2): EXEC1 n=0, z=1, p=0, SEXT=0010, pc_ld=0, mem_wr_en=0.
- ir=16'h4805 (JSR +5): EXEC1 pc_ld=1, JMP_RET_JSRR=0, SEXT=0001, w_data_sel=1, wr_addr=7, wr_en=1.
- ir=16'hF025 (TRAP): DECODE -> HALT, halted=1, ir_ld stays 0 for 20 cycles; rst -> INIT, halted=0. With PUNC_INSTR_COUNT_EN, instr_count does not increment on TRAP and reads 0 after rst.

Source files
------------

// File: rtl/punc_control.sv
// Multi-cycle control FSM for the PUnC LC3 datapath: decodes ir and drives every datapath strobe/select.
// Optional PUNC_INSTR_COUNT_EN adds a retired-instruction counter output (instr_count).
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  output logic        mem_wr_en,
  output logic [2:0]  mem_r_addr_sel,
  output logic        state2_STI,
  output logic        STR,
  output logic [2:0]  RF_wr_addr,
  output logic        RF_wr_en,
  output logic [2:0]  RF_r_addr_0,
  output logic [2:0]  RF_r_addr_1,
  output logic [1:0]  RF_w_data_sel,
  output logic        ir_ld,
  output logic        JMP_RET_JSRR,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        add_const,
  output logic [1:0]  alu_sel,
  output logic        cc_en,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic [10:0] const_n,
  output logic [3:0]  SEXT_Select,
  output logic        halted
`ifdef PUNC_INSTR_COUNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    INIT,
    FETCH,
    DECODE,
    EXEC1,
    EXEC2,
    CC_UPD,
    HALT
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_NOT  = 2'd3;

  localparam logic [3:0] SEXT_IMM5  = 4'b1000;
  localparam logic [3:0] SEXT_OFF6  = 4'b0100;
  localparam logic [3:0] SEXT_OFF9  = 4'b0010;
  localparam logic [3:0] SEXT_OFF11 = 4'b0001;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_PC   = 2'd1;
  localparam logic [1:0] WD_MEM  = 2'd2;
  localparam logic [1:0] WD_PCOF = 2'd3;

  state_t     state, next_state;
  logic [3:0] opcode;
  logic [2:0] dr, sr1;

  assign opcode = ir[15:12];
  assign dr     = ir[11:9];
  assign sr1    = ir[8:6];

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = INIT;
    case (state)
      INIT:   next_state = FETCH;
      FETCH:  next_state = DECODE;
      DECODE: next_state = (opcode == OP_TRAP) ? HALT : EXEC1;
      EXEC1: begin
        case (opcode)
          OP_LD, OP_LDR, OP_LEA: next_state = CC_UPD;
          OP_LDI, OP_STI:        next_state = EXEC2;
          default:               next_state = FETCH;
        endcase
      end
      EXEC2:  next_state = (opcode == OP_LDI) ? CC_UPD : FETCH;
      CC_UPD: next_state = FETCH;
      HALT:   next_state = HALT;
      default: next_state = INIT;
    endcase
  end

  always_comb begin
    mem_wr_en      = 1'b0;
    mem_r_addr_sel = 3'd0;
    state2_STI     = 1'b0;
    STR            = 1'b0;
    RF_wr_addr     = 3'd0;
    RF_wr_en       = 1'b0;
    RF_r_addr_0    = 3'd0;
    RF_r_addr_1    = 3'd0;
    RF_w_data_sel  = WD_ALU;
    ir_ld          = 1'b0;
    JMP_RET_JSRR   = 1'b0;
    pc_ld          = 1'b0;
    pc_clr         = 1'b0;
    pc_up          = 1'b0;
    add_const      = 1'b0;
    alu_sel        = ALU_PASS;
    cc_en          = 1'b0;
    n              = 1'b0;
    z              = 1'b0;
    p              = 1'b0;
    const_n        = ir[10:0];
    SEXT_Select    = 4'b0000;
    halted         = 1'b0;

    case (state)
      INIT: pc_clr = 1'b1;
      FETCH: begin
        mem_r_addr_sel = 3'd0;
        ir_ld          = 1'b1;
        pc_up          = 1'b1;
      end
      EXEC1: begin
        case (opcode)
          OP_ADD, OP_AND: begin
            RF_r_addr_0   = sr1;
            RF_r_addr_1   = ir[2:0];
            add_const     = ir[5];
            SEXT_Select   = SEXT_IMM5;
            alu_sel       = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
            RF_w_data_sel = WD_ALU;
            RF_wr_addr    = dr;
            RF_wr_en      = 1'b1;
            cc_en         = 1'b1;
          end
          OP_NOT: begin
            RF_r_addr_0   = sr1;
            alu_sel       = ALU_NOT;
            RF_w_data_sel = WD_ALU;
            RF_wr_addr    = dr;
            RF_wr_en      = 1'b1;
            cc_en         = 1'b1;
          end
          OP_LD: begin
            mem_r_addr_sel = 3'd1;
            SEXT_Select    = SEXT_OFF9;
            RF_w_data_sel  = WD_MEM;
            RF_wr_addr     = dr;
            RF_wr_en       = 1'b1;
          end
          OP_LDR: begin
            RF_r_addr_0    = sr1;
            add_const      = 1'b1;
            SEXT_Select    = SEXT_OFF6;
            alu_sel        = ALU_ADD;
            mem_r_addr_sel = 3'd4;
            RF_w_data_sel  = WD_MEM;
            RF_wr_addr     = dr;
            RF_wr_en       = 1'b1;
          end
          OP_LDI, OP_STI: begin
            mem_r_addr_sel = 3'd1;
            SEXT_Select    = SEXT_OFF9;
          end
          OP_LEA: begin
            SEXT_Select   = SEXT_OFF9;
            RF_w_data_sel = WD_PCOF;
            RF_wr_addr    = dr;
            RF_wr_en      = 1'b1;
          end
          OP_ST: begin
            RF_r_addr_0 = dr;
            alu_sel     = ALU_PASS;
            SEXT_Select = SEXT_OFF9;
            mem_wr_en   = 1'b1;
          end
          OP_STR: begin
            STR         = 1'b1;
            RF_r_addr_0 = sr1;
            RF_r_addr_1 = dr;
            add_const   = 1'b1;
            SEXT_Select = SEXT_OFF6;
            alu_sel     = ALU_ADD;
            mem_wr_en   = 1'b1;
          end
          OP_BR: begin
            n           = ir[11];
            z           = ir[10];
            p           = ir[9];
            SEXT_Select = SEXT_OFF9;
          end
          OP_JMP: begin
            RF_r_addr_0  = sr1;
            alu_sel      = ALU_PASS;
            JMP_RET_JSRR = 1'b1;
            pc_ld        = 1'b1;
          end
          OP_JSR: begin
            // R7 takes the already-incremented PC on the same edge the PC loads, so Base=R7 reads the old R7
            if (ir[11]) begin
              SEXT_Select = SEXT_OFF11;
            end else begin
              RF_r_addr_0  = sr1;
              alu_sel      = ALU_PASS;
              JMP_RET_JSRR = 1'b1;
            end
            pc_ld         = 1'b1;
            RF_w_data_sel = WD_PC;
            RF_wr_addr    = 3'd7;
            RF_wr_en      = 1'b1;
          end
          default: ;
        endcase
      end
      EXEC2: begin
        case (opcode)
          OP_LDI: begin
            mem_r_addr_sel = 3'd2;
            RF_w_data_sel  = WD_MEM;
            RF_wr_addr     = dr;
            RF_wr_en       = 1'b1;
          end
          OP_STI: begin
            state2_STI  = 1'b1;
            RF_r_addr_0 = dr;
            alu_sel     = ALU_PASS;
            mem_wr_en   = 1'b1;
          end
          default: ;
        endcase
      end
      CC_UPD: begin
        RF_r_addr_0 = dr;
        alu_sel     = ALU_PASS;
        cc_en       = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef PUNC_INSTR_COUNT_EN
  logic retire;
  assign retire = (state == EXEC1 || state == EXEC2 || state == CC_UPD) && (next_state == FETCH);

  always_ff @(posedge clk) begin
    if (rst)         instr_count <= '0;
    else if (retire) instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: expected control vectors are queued per cycle and compared at negedge.
module tb_punc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        mem_wr_en, state2_STI, STR, RF_wr_en, ir_ld, JMP_RET_JSRR;
  logic        pc_ld, pc_clr, pc_up, add_const, cc_en, n, z, p, halted;
  logic [2:0]  mem_r_addr_sel, RF_wr_addr, RF_r_addr_0, RF_r_addr_1;
  logic [1:0]  RF_w_data_sel, alu_sel;
  logic [10:0] const_n;
  logic [3:0]  SEXT_Select;
`ifdef PUNC_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  always #5 clk = ~clk;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir),
    .mem_wr_en(mem_wr_en), .mem_r_addr_sel(mem_r_addr_sel), .state2_STI(state2_STI),
    .STR(STR), .RF_wr_addr(RF_wr_addr), .RF_wr_en(RF_wr_en),
    .RF_r_addr_0(RF_r_addr_0), .RF_r_addr_1(RF_r_addr_1), .RF_w_data_sel(RF_w_data_sel),
    .ir_ld(ir_ld), .JMP_RET_JSRR(JMP_RET_JSRR), .pc_ld(pc_ld), .pc_clr(pc_clr),
    .pc_up(pc_up), .add_const(add_const), .alu_sel(alu_sel), .cc_en(cc_en),
    .n(n), .z(z), .p(p), .const_n(const_n), .SEXT_Select(SEXT_Select), .halted(halted)
`ifdef PUNC_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  typedef struct packed {
    logic        mem_wr_en;
    logic [2:0]  mem_r_addr_sel;
    logic        state2_STI;
    logic        STR;
    logic [2:0]  wr_addr;
    logic        wr_en;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic [1:0]  wd_sel;
    logic        ir_ld;
    logic        jmp;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_up;
    logic        add_const;
    logic [1:0]  alu_sel;
    logic        cc_en;
    logic        n;
    logic        z;
    logic        p;
    logic [10:0] const_n;
    logic [3:0]  sext;
    logic        halted;
  } ctl_t;

  ctl_t obs;
  assign obs = {mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
                RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR, pc_ld,
                pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p, const_n,
                SEXT_Select, halted};

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  ctl_t  exp_q[$];
  string tag_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {18'd0, obs}, {18'd0, e});
    end
  end

  // Push this cycle's expectation, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input ctl_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t base(input logic [15:0] i);
    ctl_t e;
    e = '0;
    e.const_n = i[10:0];
    return e;
  endfunction

  function automatic ctl_t init_e(input logic [15:0] i);
    ctl_t e;
    e = base(i);
    e.pc_clr = 1'b1;
    return e;
  endfunction

  function automatic ctl_t fetch_e(input logic [15:0] i);
    ctl_t e;
    e = base(i);
    e.ir_ld = 1'b1;
    e.pc_up = 1'b1;
    return e;
  endfunction

  task automatic check_cnt(input string tag, input logic [15:0] want);
`ifdef PUNC_INSTR_COUNT_EN
    check(tag, {48'd0, instr_count}, {48'd0, want});
`endif
  endtask

  initial begin
    ctl_t e;
    rst = 1'b1;
    ir  = 16'h0000;
    @(posedge clk);
    #1;
    cyc("reset_hold", init_e(ir));
    rst = 1'b0;
    check_cnt("cnt_reset", 16'd0);
    ir = 16'h1261;
    cyc("init", init_e(ir));
    cyc("add_fetch", fetch_e(ir));
    cyc("add_decode", base(ir));
    e = base(ir);
    e.r0 = 3'd1; e.r1 = 3'd1; e.add_const = 1'b1; e.sext = 4'b1000;
    e.alu_sel = 2'd1; e.wr_addr = 3'd1; e.wr_en = 1'b1; e.cc_en = 1'b1;
    cyc("add_exec1", e);
    check_cnt("cnt_add", 16'd1);

    ir = 16'hA402;
    cyc("ldi_fetch", fetch_e(ir));
    cyc("ldi_decode", base(ir));
    e = base(ir); e.mem_r_addr_sel = 3'd1; e.sext = 4'b0010;
    cyc("ldi_exec1", e);
    e = base(ir); e.mem_r_addr_sel = 3'd2; e.wd_sel = 2'd2; e.wr_addr = 3'd2; e.wr_en = 1'b1;
    cyc("ldi_exec2", e);
    e = base(ir); e.r0 = 3'd2; e.cc_en = 1'b1;
    cyc("ldi_ccupd", e);
    check_cnt("cnt_ldi", 16'd2);

    ir = 16'h05FE;
    cyc("br_fetch", fetch_e(ir));
    cyc("br_decode", base(ir));
    e = base(ir); e.z = 1'b1; e.sext = 4'b0010;
    cyc("br_exec1", e);
    check_cnt("cnt_br", 16'd3);

    ir = 16'h4805;
    cyc("jsr_fetch", fetch_e(ir));
    cyc("jsr_decode", base(ir));
    e = base(ir); e.pc_ld = 1'b1; e.sext = 4'b0001; e.wd_sel = 2'd1; e.wr_addr = 3'd7; e.wr_en = 1'b1;
    cyc("jsr_exec1", e);
    check_cnt("cnt_jsr", 16'd4);

    ir = 16'h7E81;
    cyc("str_fetch", fetch_e(ir));
    cyc("str_decode", base(ir));
    e = base(ir); e.STR = 1'b1; e.r0 = 3'd2; e.r1 = 3'd7; e.add_const = 1'b1;
    e.sext = 4'b0100; e.alu_sel = 2'd1; e.mem_wr_en = 1'b1;
    cyc("str_exec1", e);

    ir = 16'h41C0;
    cyc("jsrr_fetch", fetch_e(ir));
    cyc("jsrr_decode", base(ir));
    e = base(ir); e.r0 = 3'd7; e.jmp = 1'b1; e.pc_ld = 1'b1;
    e.wd_sel = 2'd1; e.wr_addr = 3'd7; e.wr_en = 1'b1;
    cyc("jsrr_exec1", e);
    check_cnt("cnt_jsrr", 16'd6);

    ir = 16'hA402;
    cyc("ldi2_fetch", fetch_e(ir));
    cyc("ldi2_decode", base(ir));
    e = base(ir); e.mem_r_addr_sel = 3'd1; e.sext = 4'b0010;
    cyc("ldi2_exec1", e);
    rst = 1'b1;
    e = base(ir); e.mem_r_addr_sel = 3'd2; e.wd_sel = 2'd2; e.wr_addr = 3'd2; e.wr_en = 1'b1;
    cyc("ldi2_exec2_rst", e);
    rst = 1'b0;
    check_cnt("cnt_abort", 16'd0);
    cyc("abort_init", init_e(ir));

    ir = 16'hF025;
    cyc("trap_fetch", fetch_e(ir));
    cyc("trap_decode", base(ir));
    e = base(ir); e.halted = 1'b1;
    for (int i = 0; i < 20; i++) cyc("trap_halt", e);
    check_cnt("cnt_trap", 16'd0);
    rst = 1'b1;
    cyc("halt_rst", e);
    rst = 1'b0;
    cyc("post_halt_init", init_e(ir));
    check_cnt("cnt_post_halt", 16'd0);
    cyc("post_halt_fetch", fetch_e(ir));

    @(negedge clk);
    check("queue_drained", {32'd0, exp_q.size()}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
